inst_fetch_responder: RTL

Memory-side responder for the instruction fetch stage. Accepts a 32-bit fetch address, reads the instruction as four little-endian bytes over the byte-wide RAM port (1-cycle read latency), and returns the assembled word with a valid/accept handshake. Sits between the fetch unit and the memory arbiter. An optional direct-mapped instruction cache short-circuits repeat fetches.

---
 rtl/cpu_defs_pkg.sv | 14 +
 rtl/icache_array.sv | 63 ++++++
 rtl/inst_fetch_responder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared fetch-stage definitions: fetch FSM state encoding and datapath widths.
package cpu_defs_pkg;

  localparam int XLEN       = 32;
  localparam int INST_WIDTH = 32;
  localparam int KCNT_W     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped instruction cache storage with combinational lookup and synchronous fill.
// Compiled only when ICACHE_EN is defined.
`ifdef ICACHE_EN
module icache_array
  import cpu_defs_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [XLEN-3:0]       rd_waddr,
  output logic                  rd_hit,
  output logic [INST_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [XLEN-3:0]       wr_waddr,
  input  logic [INST_WIDTH-1:0] wr_data
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = XLEN - 2 - IDX_W;

  logic [LINES-1:0]      valid_q;
  logic [LINES-1:0]      valid_d;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [INST_WIDTH-1:0] data_q [LINES];
  logic [IDX_W-1:0]      rd_idx_s;
  logic [IDX_W-1:0]      wr_idx_s;

  assign rd_idx_s = rd_waddr[IDX_W-1:0];
  assign wr_idx_s = wr_waddr[IDX_W-1:0];

  always_comb begin
    rd_hit  = valid_q[rd_idx_s] && (tag_q[rd_idx_s] == rd_waddr[XLEN-3:IDX_W]);
    rd_data = data_q[rd_idx_s];
  end

  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[wr_idx_s] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data carry no reset; the valid bits gate every use of them.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_q[wr_idx_s]  <= wr_waddr[XLEN-3:IDX_W];
      data_q[wr_idx_s] <= wr_data;
    end
  end

endmodule
`endif

// File: rtl/inst_fetch_responder.sv
// Fetch responder: assembles a 32-bit instruction from four byte reads with restart on any gap.
// Optional direct-mapped instruction cache enabled by defining ICACHE_EN.
module inst_fetch_responder
  import cpu_defs_pkg::*;
#(
  parameter int ICACHE_LINES = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  input  logic                  req_valid,
  input  logic [XLEN-1:0]       req_addr,
  output logic                  req_ready,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst_out,
  input  logic                  inst_accept,
  output logic                  mem_req,
  input  logic                  mem_grant,
  output logic [XLEN-1:0]       mem_a,
  input  logic [7:0]            mem_din
);

  fetch_state_e          state_q, state_d;
  logic [KCNT_W-1:0]     k_q, k_d;
  logic [XLEN-1:0]       base_q, base_d;
  logic [INST_WIDTH-1:0] inst_out_q, inst_out_d;
  logic [KCNT_W-1:0]     k_sat_s;
  logic                  hit_s;
  logic [INST_WIDTH-1:0] cache_data_s;
  logic                  cache_we_s;
  logic                  unused_s;

`ifdef ICACHE_EN
  icache_array #(
    .LINES (ICACHE_LINES)
  ) u_icache (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rd_waddr (req_addr[XLEN-1:2]),
    .rd_hit   (hit_s),
    .rd_data  (cache_data_s),
    .wr_en    (cache_we_s),
    .wr_waddr (base_q[XLEN-1:2]),
    .wr_data  (inst_out_d)
  );
  assign unused_s = ^req_addr[1:0];
`else
  assign hit_s        = 1'b0;
  assign cache_data_s = '0;
  assign unused_s     = ^{req_addr[1:0], cache_we_s, (ICACHE_LINES != 0)};
`endif

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    base_d     = base_q;
    inst_out_d = inst_out_q;
    cache_we_s = 1'b0;
    if (rdy_in && flush) begin
      state_d = IDLE;
      k_d     = '0;
    end else if (rdy_in) begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            base_d = {req_addr[XLEN-1:2], 2'b00};
            k_d    = '0;
            if (hit_s) begin
              inst_out_d = cache_data_s;
              state_d    = DONE;
            end else begin
              state_d = READ;
            end
          end else begin
            state_d = IDLE;
          end
        end
        READ: begin
          // mem_din answers last cycle's address, so byte k-1 lands while k is issued.
          if (mem_grant) begin
            case (k_q)
              3'd1:    inst_out_d[7:0]   = mem_din;
              3'd2:    inst_out_d[15:8]  = mem_din;
              3'd3:    inst_out_d[23:16] = mem_din;
              3'd4:    inst_out_d[31:24] = mem_din;
              default: inst_out_d        = inst_out_q;
            endcase
            if (k_q == 3'd4) begin
              k_d        = '0;
              state_d    = DONE;
              cache_we_s = 1'b1;
            end else begin
              k_d = k_q + 3'd1;
            end
          end else begin
            k_d = '0;
          end
        end
        DONE: begin
          if (inst_accept) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
          k_d     = '0;
        end
      endcase
    end else if (state_q == READ) begin
      k_d = '0;
    end else begin
      k_d = k_q;
    end
  end

  always_comb begin
    if (k_q == 3'd4) begin
      k_sat_s = 3'd3;
    end else begin
      k_sat_s = k_q;
    end
    mem_req    = (state_q == READ);
    inst_valid = (state_q == DONE);
    req_ready  = (state_q == IDLE) && rdy_in && !rst_in;
    if (mem_req) begin
      mem_a = base_q + {{(XLEN-KCNT_W){1'b0}}, k_sat_s};
    end else begin
      mem_a = '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      k_q        <= '0;
      base_q     <= '0;
      inst_out_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      base_q     <= base_d;
      inst_out_q <= inst_out_d;
    end
  end

  assign inst_out = inst_out_q;

endmodule
